countdown_timer: RTL

Minutes:seconds countdown timer for the alarm clock, the count-down counterpart of the up-counting minute/second chain. It loads a preset MM:SS, decrements once per 1 Hz enable tick while running, and raises a one-cycle `expired` pulse and a sticky `done` level on reaching 00:00. It sits beside the timekeeping counters, fed by the same 1 Hz tick, and drives the display mux and alarm buzzer logic.

---
 rtl/timer_pkg.sv | 14 +
 rtl/down60.sv | 33 +++
 rtl/countdown_timer.sv | 104 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state type and constants for the countdown timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tmr_state_t;

    localparam int TMR_W   = 6;
    localparam int SEC_MAX = 59;

endpackage

// File: rtl/down60.sv
// rtl/down60.sv - modulo-60 down counter with load and borrow flag
module down60
    import timer_pkg::*;
#(
    parameter int MAX = SEC_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic [TMR_W-1:0] count,
    output logic             borrow
);

    localparam logic [TMR_W-1:0] MAX_V = TMR_W'(MAX);
    localparam logic [TMR_W-1:0] ONE_V = TMR_W'(1);

    // Borrow flags the wrap from 0 back to MAX so the next digit can step down.
    assign borrow = en && (count == '0);

    // Count register: load wins over decrement, decrement wraps to MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == '0) ? MAX_V : count - ONE_V;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS countdown timer with run/pause control and expiry flags
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_min,
    input  logic [TMR_W-1:0] load_sec,
    input  logic             start,
    input  logic             stop,
    output logic [TMR_W-1:0] min,
    output logic [TMR_W-1:0] sec,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam logic [TMR_W-1:0] MAX_MIN_V = TMR_W'(MAX_MIN);
    localparam logic [TMR_W-1:0] MAX_SEC_V = TMR_W'(MAX_SEC);
    localparam logic [TMR_W-1:0] ONE_V     = TMR_W'(1);

    tmr_state_t       state;
    tmr_state_t       nxt_state;
    logic [TMR_W-1:0] nxt_min;
    logic             nxt_expired;
    logic             sec_load;
    logic [TMR_W-1:0] sec_load_val;
    logic             sec_en;
    logic             sec_borrow;
    logic             count_zero;
    logic [TMR_W-1:0] min_clamped;
    logic [TMR_W-1:0] sec_clamped;

    assign count_zero  = (min == '0) && (sec == '0);
    assign min_clamped = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
    assign sec_clamped = (load_sec > MAX_SEC_V) ? MAX_SEC_V : load_sec;

    down60 #(
        .MAX (MAX_SEC)
    ) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (sec_en),
        .load     (sec_load),
        .load_val (sec_load_val),
        .count    (sec),
        .borrow   (sec_borrow)
    );

    // Command decode in priority order; an ignored command falls through to the next one.
    always_comb begin
        nxt_state    = state;
        nxt_min      = min;
        nxt_expired  = 1'b0;
        sec_load     = 1'b0;
        sec_load_val = '0;
        sec_en       = 1'b0;
        if (clear) begin
            nxt_state = IDLE;
            nxt_min   = '0;
            sec_load  = 1'b1;
        end else if (load && (state != RUN)) begin
            nxt_state    = IDLE;
            nxt_min      = min_clamped;
            sec_load     = 1'b1;
            sec_load_val = sec_clamped;
        end else if (stop && (state == RUN)) begin
            nxt_state = PAUSE;
        end else if (start && ((state == IDLE) || (state == PAUSE)) && !count_zero) begin
            nxt_state = RUN;
        end else if (tick && (state == RUN) && !count_zero) begin
            sec_en = 1'b1;
            if ((min == '0) && (sec == ONE_V)) begin
                nxt_state   = DONE;
                nxt_expired = 1'b1;
            end
        end
    end

    // State, minutes and registered flags; minutes step down on the seconds borrow,
    // which is taken from the counter rather than the decode to keep the paths acyclic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            min     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= nxt_state;
            min     <= sec_borrow ? (min - ONE_V) : nxt_min;
            running <= (nxt_state == RUN);
            done    <= (nxt_state == DONE);
            expired <= nxt_expired;
        end
    end

endmodule
